// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Slot records and forwarding-select encodings used by the top and the bench.
package hazard_forward_ctrl_pkg;

  localparam int unsigned REG_AW_DFLT = 5;
  localparam int unsigned FWD_W       = 2;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

  typedef logic [REG_AW_DFLT-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t dest;
    logic      wb_en;
    logic      mem_read;
  } slot_t;

  typedef struct packed {
    reg_addr_t src1;
    reg_addr_t src2;
    logic      src2_used;
    slot_t     slot;
  } exe_slot_t;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic src_match(input reg_addr_t src, input reg_addr_t dest,
                                     input logic wb_en);
    return (src != '0) && (src == dest) && wb_en;
  endfunction

  // MEM result is the youngest producer, so it wins over WB.
  function automatic logic [FWD_W-1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_sat.sv
// Saturating event counter used for stall/flush performance statistics.
// Counts up on each clock with i_inc high and sticks at all-ones.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, branch flush and EXE operand forwarding for the 5-stage core.
// Tracks destination info of the EXE/MEM/WB instructions in shadow slots.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DFLT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic [FWD_W-1:0]  fwd_sel1,
  output logic [FWD_W-1:0]  fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  exe_slot_t r_exe;
  slot_t     r_mem;
  reg_addr_t r_wb_dest;
  logic      r_wb_wb_en;

  exe_slot_t w_exe_nxt;
  logic      w_id1_exe, w_id2_exe, w_id1_mem, w_id2_mem;
  logic      w_hazard;
  logic      w_ex1_mem, w_ex2_mem, w_ex1_wb, w_ex2_wb;

  // ID-stage sources against the older in-flight instructions.
  assign w_id1_exe = src_match(id_src1, r_exe.slot.dest, r_exe.slot.wb_en);
  assign w_id2_exe = id_src2_used && src_match(id_src2, r_exe.slot.dest, r_exe.slot.wb_en);
  assign w_id1_mem = src_match(id_src1, r_mem.dest, r_mem.wb_en);
  assign w_id2_mem = id_src2_used && src_match(id_src2, r_mem.dest, r_mem.wb_en);

  // WB never stalls: the register file writes before it is read in that cycle.
  always_comb begin
    w_hazard = 1'b0;
    if (forward_en) begin
      w_hazard = (w_id1_exe || w_id2_exe) && r_exe.slot.mem_read;
    end else begin
      w_hazard = w_id1_exe || w_id2_exe || w_id1_mem || w_id2_mem;
    end
  end

  // Flush squashes the stalled ID instruction, so it takes priority.
  assign flush = branch_taken && !rst;
  assign stall = w_hazard && !branch_taken && !rst;

  // A load in MEM has no result yet, so it is never a forwarding source.
  assign w_ex1_mem = src_match(r_exe.src1, r_mem.dest, r_mem.wb_en) && !r_mem.mem_read;
  assign w_ex2_mem = src_match(r_exe.src2, r_mem.dest, r_mem.wb_en) && !r_mem.mem_read;
  assign w_ex1_wb  = src_match(r_exe.src1, r_wb_dest, r_wb_wb_en);
  assign w_ex2_wb  = src_match(r_exe.src2, r_wb_dest, r_wb_wb_en);

  always_comb begin
    fwd_sel1 = FWD_REG;
    fwd_sel2 = FWD_REG;
    if (forward_en) begin
      fwd_sel1 = fwd_pick(w_ex1_mem, w_ex1_wb);
      if (r_exe.src2_used) begin
        fwd_sel2 = fwd_pick(w_ex2_mem, w_ex2_wb);
      end
    end
  end

  // A stalled or flushed ID instruction becomes a bubble in EXE.
  always_comb begin
    w_exe_nxt = '0;
    if (!stall && !flush) begin
      w_exe_nxt.src1          = id_src1;
      w_exe_nxt.src2          = id_src2;
      w_exe_nxt.src2_used     = id_src2_used;
      w_exe_nxt.slot.dest     = id_dest;
      w_exe_nxt.slot.wb_en    = id_wb_en;
      w_exe_nxt.slot.mem_read = id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exe      <= '0;
      r_mem      <= '0;
      r_wb_dest  <= '0;
      r_wb_wb_en <= 1'b0;
    end else begin
      r_exe      <= w_exe_nxt;
      r_mem      <= r_exe.slot;
      r_wb_dest  <= r_mem.dest;
      r_wb_wb_en <= r_mem.wb_en;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (stall),
    .o_cnt (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (flush),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a vector table of instruction streams
// plus hand sequences for counter saturation and asynchronous reset.
module tb_hazard_forward_ctrl;
  import hazard_forward_ctrl_pkg::*;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SCNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             forward_en;
  logic [4:0]       id_src1, id_src2, id_dest;
  logic             id_src2_used, id_wb_en, id_mem_read, branch_taken;
  logic             stall, flush;
  logic [1:0]       fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             s_stall, s_flush;
  logic [1:0]       s_fwd1, s_fwd2;
  logic [SCNT_W-1:0] s_scnt, s_fcnt;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall(stall), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(SCNT_W)) dut_s (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .stall(s_stall), .flush(s_flush),
    .fwd_sel1(s_fwd1), .fwd_sel2(s_fwd2),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  typedef struct {
    logic       fe;
    logic [4:0] s1, s2;
    logic       s2u;
    logic [4:0] d;
    logic       wb, mr, br;
    logic       x_stall, x_flush;
    logic [1:0] x_f1, x_f2;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  logic [CNT_W-1:0]  m_scnt  = '0;
  logic [CNT_W-1:0]  m_fcnt  = '0;
  logic [SCNT_W-1:0] m_scnt4 = '0;
  logic [SCNT_W-1:0] m_fcnt4 = '0;
  vec_t tbl[$];

  // A load still in MEM must never be a live EXE source; the load-use stall prevents it.
  always @(negedge clk) begin
    if (!rst) begin
      a_no_mem_load_src: assert (!(dut.r_mem.mem_read && dut.r_mem.wb_en &&
          ((dut.r_exe.src1 != 5'd0 && dut.r_exe.src1 == dut.r_mem.dest) ||
           (dut.r_exe.src2_used && dut.r_exe.src2 != 5'd0 && dut.r_exe.src2 == dut.r_mem.dest))))
        else $error("load in MEM slot feeds an EXE source at %0t", $time);
    end
  end

  function automatic vec_t mk(input int fe, input int s1, input int s2, input int s2u,
                              input int d, input int wb, input int mr, input int br,
                              input int xs, input int xf, input int xf1, input int xf2);
    vec_t v;
    v.fe = 1'(fe); v.s1 = 5'(s1); v.s2 = 5'(s2); v.s2u = 1'(s2u);
    v.d = 5'(d); v.wb = 1'(wb); v.mr = 1'(mr); v.br = 1'(br);
    v.x_stall = 1'(xs); v.x_flush = 1'(xf); v.x_f1 = 2'(xf1); v.x_f2 = 2'(xf2);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Apply one ID-stage instruction for one cycle and check everything at negedge.
  task automatic step(input vec_t v, input string tag);
    forward_en = v.fe; id_src1 = v.s1; id_src2 = v.s2; id_src2_used = v.s2u;
    id_dest = v.d; id_wb_en = v.wb; id_mem_read = v.mr; branch_taken = v.br;
    @(negedge clk);
    chk({tag, ".stall"},  32'(stall),     32'(v.x_stall));
    chk({tag, ".flush"},  32'(flush),     32'(v.x_flush));
    chk({tag, ".fwd1"},   32'(fwd_sel1),  32'(v.x_f1));
    chk({tag, ".fwd2"},   32'(fwd_sel2),  32'(v.x_f2));
    chk({tag, ".scnt"},   32'(stall_cnt), 32'(m_scnt));
    chk({tag, ".fcnt"},   32'(flush_cnt), 32'(m_fcnt));
    chk({tag, ".s_out"},  32'({s_stall, s_flush, s_fwd1, s_fwd2}),
        32'({v.x_stall, v.x_flush, v.x_f1, v.x_f2}));
    chk({tag, ".s_scnt"}, 32'(s_scnt),    32'(m_scnt4));
    chk({tag, ".s_fcnt"}, 32'(s_fcnt),    32'(m_fcnt4));
    if (v.x_stall && m_scnt  != '1) m_scnt  = m_scnt  + CNT_W'(1);
    if (v.x_stall && m_scnt4 != '1) m_scnt4 = m_scnt4 + SCNT_W'(1);
    if (v.x_flush && m_fcnt  != '1) m_fcnt  = m_fcnt  + CNT_W'(1);
    if (v.x_flush && m_fcnt4 != '1) m_fcnt4 = m_fcnt4 + SCNT_W'(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              fe s1 s2 u  d wb mr br  st fl f1 f2
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0)); // A dest3
    tbl.push_back(mk(1, 3, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0)); // B uses 3, no stall
    tbl.push_back(mk(1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0)); // B in EXE: MEM fwd
    tbl.push_back(mk(1, 4, 6, 1,10, 1, 0, 0, 0, 0, 0, 0)); // D uses 4 and 6
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1)); // D in EXE: WB / MEM
    tbl.push_back(mk(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0)); // F dest8
    tbl.push_back(mk(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0)); // G dest8
    tbl.push_back(mk(1, 8, 8, 1,11, 1, 0, 0, 0, 0, 0, 0)); // H uses 8 twice
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // MEM beats WB
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); // writes r0
    tbl.push_back(mk(0, 0, 0, 1,12, 1, 0, 0, 0, 0, 0, 0)); // reads r0, no stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // r0 never forwards
    tbl.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0)); // load dest5
    tbl.push_back(mk(1, 0, 5, 1, 9, 1, 0, 0, 1, 0, 0, 0)); // load-use stall
    tbl.push_back(mk(1, 0, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0)); // released after 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // ADD gets WB data
    tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0)); // A2 dest7, no fwd
    tbl.push_back(mk(0, 7, 0, 0,13, 1, 0, 0, 1, 0, 0, 0)); // stall on EXE
    tbl.push_back(mk(0, 7, 0, 0,13, 1, 0, 0, 1, 0, 0, 0)); // stall on MEM
    tbl.push_back(mk(0, 7, 0, 0,13, 1, 0, 0, 0, 0, 0, 0)); // WB: released
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // WB match but fwd off
    tbl.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0)); // load dest5
    tbl.push_back(mk(1, 0, 5, 1, 9, 1, 0, 1, 0, 1, 0, 0)); // flush beats load-use
    tbl.push_back(mk(1, 9, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // EXE is a bubble
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)); // flushed ADD gone

    rst = 1'b1; forward_en = 1'b1; id_src1 = '0; id_src2 = '0; id_src2_used = 1'b0;
    id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    chk("reset.out",  32'({stall, flush, fwd_sel1, fwd_sel2}), 32'd0);
    chk("reset.cnt",  32'({stall_cnt, flush_cnt}), 32'd0);
    chk("reset.scnt", 32'({s_scnt, s_fcnt}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nop0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "nop1");
    // Self-dependent stream: two stall cycles out of every three.
    for (int k = 0; k < 31; k++)
      step(mk(0, 7, 0, 0, 7, 1, 0, 0, int'(k % 3 != 0), 0, 0, 0), $sformatf("sat%0d", k));
    chk("sat.s_scnt", 32'(s_scnt), 32'hF);
    chk("sat.scnt",   32'(stall_cnt), 32'd23);

    #1;
    chk("mid.stall", 32'(stall), 32'd1);
    branch_taken = 1'b1;
    #1;
    chk("mid.prio", 32'({stall, flush}), 32'b01);
    rst = 1'b1;
    #1;
    chk("arst.out",  32'({stall, flush, fwd_sel1, fwd_sel2}), 32'd0);
    chk("arst.cnt",  32'({stall_cnt, flush_cnt}), 32'd0);
    chk("arst.scnt", 32'({s_scnt, s_fcnt}), 32'd0);
    m_scnt = '0; m_fcnt = '0; m_scnt4 = '0; m_fcnt4 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0), "post0");
    step(mk(0, 7, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0), "post1");
    step(mk(0, 7, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0), "post2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
